// File: rtl/uart_tx_dev.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_dev                                                  |
// | Description : Memory-mapped 8N1 UART transmitter for a SouthBridge device  |
// |               slot. The CPU pushes bytes into a DEPTH-entry FIFO; the FSM  |
// |               serialises them LSB first on TxD at DIVISOR clocks per bit.  |
// |               IRQ is a level request raised once the transmitter drains.   |
// | Ports       : clk   - system clock, rising edge                            |
// |               reset - asynchronous, active-low reset                       |
// |               Addr  - byte address, Addr[3:2] selects the register         |
// |               WE    - one-cycle write strobe                               |
// |               Din   - write data                                           |
// |               Dout  - read data, combinational from Addr[3:2]              |
// |               IRQ   - IRQ_EN & FIFO empty & FSM idle                       |
// |               TxD   - serial output, idle high                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_tx_dev #(
   parameter int DEPTH       = 8,
   parameter int DEFAULT_DIV = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Addr,
   input  logic        WE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ,
   output logic        TxD
);

   localparam int          c_ptr_w   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [4:0]  c_depth   = 5'(DEPTH);
   localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

   localparam logic [1:0]  c_reg_data   = 2'd0;
   localparam logic [1:0]  c_reg_status = 2'd1;
   localparam logic [1:0]  c_reg_ctrl   = 2'd2;
   localparam logic [1:0]  c_reg_div    = 2'd3;

   localparam logic [1:0]  c_st_idle  = 2'd0;
   localparam logic [1:0]  c_st_start = 2'd1;
   localparam logic [1:0]  c_st_data  = 2'd2;
   localparam logic [1:0]  c_st_stop  = 2'd3;

   // Registered state
   logic [7:0]          r_mem [DEPTH];
   logic [c_ptr_w-1:0]  r_wr_ptr;
   logic [c_ptr_w-1:0]  r_rd_ptr;
   logic [4:0]          r_count;
   logic                r_ovf;
   logic [1:0]          r_ctrl;
   logic [15:0]         r_divisor;
   logic [1:0]          r_state;
   logic [7:0]          r_shift;
   logic [2:0]          r_bit_cnt;
   logic [15:0]         r_baud;
   logic [15:0]         r_div_lat;
   logic                r_txd;

   // Combinational
   logic [1:0]          w_sel;
   logic                w_push_req;
   logic                w_push;
   logic                w_pop;
   logic                w_empty;
   logic                w_full;
   logic                w_busy;
   logic                w_can_start;
   logic                w_baud_end;
   logic [15:0]         w_div_eff;
   logic [7:0]          w_head;
   logic [1:0]          w_state_nxt;
   logic [7:0]          w_shift_nxt;
   logic                w_txd_nxt;
   logic                w_unused;

   assign w_sel       = Addr[3:2];
   assign w_push_req  = WE && (w_sel == c_reg_data);
   assign w_empty     = (r_count == 5'd0);
   assign w_full      = (r_count == c_depth);
   assign w_busy      = (r_state != c_st_idle);
   assign w_can_start = r_ctrl[0] && !w_empty;
   assign w_baud_end  = (r_baud == (r_div_lat - 16'd1));
   assign w_div_eff   = (r_divisor == 16'd0) ? 16'd1 : r_divisor;
   assign w_head      = r_mem[r_rd_ptr];

   // A full FIFO still accepts a byte when the FSM frees a slot the same edge.
   // An empty FIFO never pops, so a push into it is always accepted.
   assign w_push      = w_push_req && (!w_full || w_pop);

   assign w_unused    = &{1'b0, Addr[31:4], Addr[1:0], Din[31:16]};

   // Next-state logic; pops happen only on leaving IDLE or at the end of STOP.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
         c_st_idle: begin
            if (w_can_start) begin
               w_pop       = 1'b1;
               w_state_nxt = c_st_start;
            end
         end
         c_st_start: begin
            if (w_baud_end) w_state_nxt = c_st_data;
         end
         c_st_data: begin
            if (w_baud_end && (r_bit_cnt == 3'd7)) w_state_nxt = c_st_stop;
         end
         c_st_stop: begin
            if (w_baud_end) begin
               if (w_can_start) begin
                  w_pop       = 1'b1;
                  w_state_nxt = c_st_start;
               end else begin
                  w_state_nxt = c_st_idle;
               end
            end
         end
         default: w_state_nxt = c_st_idle;
      endcase
   end

   always_comb begin
      w_shift_nxt = r_shift;
      if (w_pop) begin
         w_shift_nxt = w_head;
      end else if ((r_state == c_st_data) && w_baud_end) begin
         w_shift_nxt = {1'b0, r_shift[7:1]};
      end
   end

   // TxD is registered from the next state so the line never glitches.
   always_comb begin
      case (w_state_nxt)
         c_st_start: w_txd_nxt = 1'b0;
         c_st_data:  w_txd_nxt = w_shift_nxt[0];
         default:    w_txd_nxt = 1'b1;
      endcase
   end

   // FIFO storage carries no reset; validity is tracked by the pointers/count.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= Din[7:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= 5'd0;
         r_ovf     <= 1'b0;
         r_ctrl    <= 2'b00;
         r_divisor <= 16'(DEFAULT_DIV);
         r_state   <= c_st_idle;
         r_shift   <= 8'h00;
         r_bit_cnt <= 3'd0;
         r_baud    <= 16'd0;
         r_div_lat <= 16'd1;
         r_txd     <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_shift <= w_shift_nxt;
         r_txd   <= w_txd_nxt;

         if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;

         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 5'd1;
            2'b01:   r_count <= r_count - 5'd1;
            default: r_count <= r_count;
         endcase

         if (WE && (w_sel == c_reg_status)) begin
            r_ovf <= 1'b0;
         end else if (w_push_req && !w_push) begin
            r_ovf <= 1'b1;
         end

         if (WE && (w_sel == c_reg_ctrl)) r_ctrl    <= Din[1:0];
         if (WE && (w_sel == c_reg_div))  r_divisor <= Din[15:0];

         // The bit period is captured per frame so DIVISOR writes mid-frame
         // only affect the following frame.
         if (w_pop) begin
            r_div_lat <= w_div_eff;
            r_baud    <= 16'd0;
            r_bit_cnt <= 3'd0;
         end else if (w_busy) begin
            if (w_baud_end) begin
               r_baud <= 16'd0;
               if (r_state == c_st_data) r_bit_cnt <= r_bit_cnt + 3'd1;
            end else begin
               r_baud <= r_baud + 16'd1;
            end
         end
      end
   end

   always_comb begin
      case (w_sel)
         c_reg_status: Dout = {23'd0, r_count, r_ovf, w_empty, w_full, w_busy};
         c_reg_ctrl:   Dout = {30'd0, r_ctrl};
         c_reg_div:    Dout = {16'd0, r_divisor};
         default:      Dout = 32'd0;
      endcase
   end

   assign IRQ = r_ctrl[1] & w_empty & (r_state == c_st_idle);
   assign TxD = r_txd;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_dev.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_tx_dev                                               |
// | Description : Self-checking bench for uart_tx_dev. A frame-timeline model  |
// |               (byte queue plus frame start time and bit period) predicts   |
// |               TxD, IRQ and Dout every cycle; directed scenarios add literal|
// |               expectations, followed by randomized register traffic.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uart_tx_dev;

   localparam int DEPTH = 8;

   logic        clk;
   logic        reset;
   logic [31:0] Addr;
   logic        WE;
   logic [31:0] Din;
   logic [31:0] Dout;
   logic        IRQ;
   logic        TxD;

   int n_checks = 0;
   int n_errors = 0;

   uart_tx_dev #(.DEPTH(DEPTH), .DEFAULT_DIV(16)) dut (
      .clk   (clk),
      .reset (reset),
      .Addr  (Addr),
      .WE    (WE),
      .Din   (Din),
      .Dout  (Dout),
      .IRQ   (IRQ),
      .TxD   (TxD)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [7:0]  m_q[$];
   logic        m_ovf     = 1'b0;
   logic [1:0]  m_ctrl    = 2'b00;
   logic [15:0] m_divisor = 16'd16;
   logic        m_active  = 1'b0;
   logic [7:0]  m_byte    = 8'h00;
   int          m_start   = 0;
   int          m_div     = 1;
   int          cyc       = 0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_q.delete();
         m_ovf     = 1'b0;
         m_ctrl    = 2'b00;
         m_divisor = 16'd16;
         m_active  = 1'b0;
      end else begin : step
         bit done;
         bit pop;
         cyc++;
         done = m_active && ((cyc - m_start) == 10 * m_div);
         pop  = (!m_active || done) && m_ctrl[0] && (m_q.size() > 0);
         if (done) m_active = 1'b0;
         if (pop) begin
            m_byte   = m_q.pop_front();
            m_start  = cyc;
            m_div    = (m_divisor == 16'd0) ? 1 : int'(m_divisor);
            m_active = 1'b1;
         end
         if (WE) begin
            case (Addr[3:2])
               2'd0: if (m_q.size() < DEPTH) m_q.push_back(Din[7:0]); else m_ovf = 1'b1;
               2'd1: m_ovf = 1'b0;
               2'd2: m_ctrl = Din[1:0];
               default: m_divisor = Din[15:0];
            endcase
         end
      end
   end

   function automatic logic exp_txd();
      int idx;
      if (!m_active) return 1'b1;
      idx = (cyc - m_start) / m_div;
      if (idx == 0) return 1'b0;
      if (idx <= 8) return m_byte[idx-1];
      return 1'b1;
   endfunction

   function automatic logic [31:0] exp_dout(input logic [31:0] a);
      logic [4:0] n;
      n = 5'(m_q.size());
      case (a[3:2])
         2'd1:    return {23'd0, n, m_ovf, (n == 5'd0), (m_q.size() == DEPTH), m_active};
         2'd2:    return {30'd0, m_ctrl};
         2'd3:    return {16'd0, m_divisor};
         default: return 32'd0;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at t=%0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      check("model_txd", {31'd0, TxD}, {31'd0, exp_txd()});
      check("model_irq", {31'd0, IRQ}, {31'd0, m_ctrl[1] && (m_q.size() == 0) && !m_active});
      check("model_dout", Dout, exp_dout(Addr));
   end

   // ---------------- stimulus helpers ----------------
   // All tasks start and end one time unit after a falling edge.
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      Addr = {28'd0, a, 2'b00};
      Din  = d;
      WE   = 1'b1;
      @(negedge clk); #1;
      WE   = 1'b0;
   endtask

   task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
      Addr = {28'd0, a, 2'b00};
      WE   = 1'b0;
      #1;
      check(name, Dout, exp);
      @(negedge clk); #1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk); #1;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [9:0]  f55;
      logic [19:0] b2b;
      logic [31:0] rv;
      int          r;

      reset = 1'b0;
      WE    = 1'b0;
      Addr  = 32'h4;
      Din   = 32'd0;
      repeat (3) @(negedge clk);
      #1 reset = 1'b1;

      // Reset values
      check("reset_txd", {31'd0, TxD}, 32'd1);
      check("reset_irq", {31'd0, IRQ}, 32'd0);
      rd("reset_status", 2'd1, 32'h4);
      rd("reset_div", 2'd3, 32'h10);
      rd("reset_ctrl", 2'd2, 32'h0);
      rd("data_reads_zero", 2'd0, 32'h0);

      // Single byte 0x55 at 4 clocks per bit
      f55 = {1'b1, 8'h55, 1'b0};
      wr(2'd3, 32'd4);
      wr(2'd2, 32'd1);
      wr(2'd0, 32'h55);
      Addr = 32'h4;
      check("single_pre_start", {31'd0, TxD}, 32'd1);
      for (int c = 0; c < 40; c++) begin
         @(negedge clk); #1;
         check("single_bit", {31'd0, TxD}, {31'd0, f55[c/4]});
         if (c == 39) check("single_busy_last", Dout, 32'h1 | 32'h4);
      end
      @(negedge clk); #1;
      check("single_done_status", Dout, 32'h4);

      // Back-to-back frames at 2 clocks per bit
      b2b = {1'b1, 8'h0F, 1'b0, 1'b1, 8'hA3, 1'b0};
      wr(2'd3, 32'd2);
      wr(2'd0, 32'hA3);
      wr(2'd0, 32'h0F);
      Addr = 32'h4;
      for (int c = 0; c < 40; c++) begin
         check("b2b_bit", {31'd0, TxD}, {31'd0, b2b[c/2]});
         @(negedge clk); #1;
      end
      check("b2b_done_status", Dout, 32'h4);

      // Overflow with transmitter disabled
      wr(2'd2, 32'd0);
      for (int i = 1; i <= 9; i++) wr(2'd0, 32'(i));
      rd("ovf_status", 2'd1, 32'h8A);
      wr(2'd1, 32'hFFFF_FFFF);
      rd("ovf_cleared", 2'd1, 32'h82);
      wr(2'd2, 32'd1);
      idle(170);
      rd("ovf_drained", 2'd1, 32'h4);

      // IRQ on drain
      wr(2'd2, 32'd3);
      check("irq_idle_high", {31'd0, IRQ}, 32'd1);
      wr(2'd0, 32'h3C);
      check("irq_after_push", {31'd0, IRQ}, 32'd0);
      for (int i = 1; i <= 21; i++) begin
         @(negedge clk); #1;
         check("irq_frame", {31'd0, IRQ}, (i == 21) ? 32'd1 : 32'd0);
      end
      wr(2'd2, 32'd1);
      check("irq_disabled", {31'd0, IRQ}, 32'd0);

      // Asynchronous reset during data bit 3 of 0xA5 (bit 3 = 0)
      wr(2'd3, 32'd4);
      wr(2'd0, 32'hA5);
      repeat (18) @(negedge clk);
      #1;
      check("arst_pre_bit3", {31'd0, TxD}, 32'd0);
      #1 reset = 1'b0;
      #1;
      check("arst_txd_now", {31'd0, TxD}, 32'd1);
      repeat (3) @(negedge clk);
      #1 reset = 1'b1;
      rd("arst_status", 2'd1, 32'h4);
      rd("arst_ctrl", 2'd2, 32'h0);
      rd("arst_div", 2'd3, 32'h10);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk); #1;
         check("arst_quiet", {31'd0, TxD}, 32'd1);
      end

      // Randomized register traffic against the model
      wr(2'd2, 32'd1);
      wr(2'd3, 32'd2);
      for (int i = 0; i < 300; i++) begin
         r  = $urandom_range(0, 12);
         rv = $urandom;
         if (r < 7) begin
            wr(2'd0, rv);
         end else if (r == 7) begin
            wr(2'd2, {rv[31:2], ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1, rv[1]});
         end else if (r == 8) begin
            wr(2'd3, {rv[31:16], 16'($urandom_range(0, 4))});
         end else if (r == 9) begin
            wr(2'd1, rv);
         end else begin
            Addr = {28'd0, rv[1:0], 2'b00};
            idle($urandom_range(1, 30));
         end
         Addr = {28'd0, rv[3:2], 2'b00};
         idle($urandom_range(0, 6));
      end

      wr(2'd2, 32'd1);
      idle(450);
      rd("rand_drained", 2'd1, {23'd0, 5'd0, m_ovf, 3'b100});

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
